instr_encoder_loader: RTL

Write-side counterpart to the main control decoder. Accepts a stream of symbolic instructions (class, registers, immediate, funct), assembles each into a 32-bit RV32I word (lw, sw, R-type, beq only, the same subset the decoder recognises), and writes the words sequentially into instruction memory. Used by the bench and boot path to load programs before the single-cycle core is released from reset.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/rv_instr_encoder.sv | 34 +++
 rtl/instr_encoder_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I subset definitions used by the main decoder and the program loader.
// Opcodes, class codes, fixed funct3 values and the loader state encoding live here.
package riscv_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] CLS_LW  = 2'b00;
    localparam logic [1:0] CLS_SW  = 2'b01;
    localparam logic [1:0] CLS_R   = 2'b10;
    localparam logic [1:0] CLS_BEQ = 2'b11;

    localparam logic [2:0] FUNCT3_LW_SW = 3'b010;
    localparam logic [2:0] FUNCT3_BEQ   = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } ld_state_e;

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational assembler: symbolic instruction fields to a 32-bit RV32I word.
// Flags R-type words whose funct7 bit 5 is set on a funct3 that has no alternate form.
module rv_instr_encoder
    import riscv_pkg::*;
(
    input  logic [1:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [31:0] instr,
    output logic        illegal
);

    always_comb begin
        instr   = '0;
        illegal = 1'b0;
        case (cls)
            CLS_LW:  instr = {imm, rs1, FUNCT3_LW_SW, rd, OP_LW};
            CLS_SW:  instr = {imm[11:5], rs2, rs1, FUNCT3_LW_SW, imm[4:0], OP_SW};
            CLS_R: begin
                instr   = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
                illegal = funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
            end
            // imm carries branch offset bits [12:1], so imm[k] is offset bit k+1
            CLS_BEQ: instr = {imm[11], imm[9:4], rs2, rs1, FUNCT3_BEQ,
                              imm[3:0], imm[10], OP_BEQ};
            default: instr = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts symbolic instructions, encodes them and writes them
// sequentially into instruction memory with a held request / ack handshake.
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_class,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [11:0]       cmd_imm,
    input  logic [2:0]        cmd_funct3,
    input  logic              cmd_funct7b5,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              err_illegal
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [31:0] enc_word;
    logic        enc_illegal;

    rv_instr_encoder u_enc (
        .cls      (cmd_class),
        .rd       (cmd_rd),
        .rs1      (cmd_rs1),
        .rs2      (cmd_rs2),
        .imm      (cmd_imm),
        .funct3   (cmd_funct3),
        .funct7b5 (cmd_funct7b5),
        .instr    (enc_word),
        .illegal  (enc_illegal)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        last_d  = last_q;
        err_d   = err_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    addr_d  = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_ACCEPT;
                end
                ST_ACCEPT: if (cmd_valid) begin
                    wdata_d = enc_word;
                    last_d  = cmd_last;
                    err_d   = err_q | enc_illegal;
                    state_d = ST_WRITE;
                end
                ST_WRITE: if (imem_ack) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    state_d = last_q ? ST_DONE : ST_ACCEPT;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        // Outputs are decoded from the next state so they register alongside it
        ready_d = (state_d == ST_ACCEPT);
        we_d    = (state_d == ST_WRITE);
        busy_d  = (state_d == ST_ACCEPT) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign count       = count_q;
    assign err_illegal = err_q;

endmodule
